hls_run_sequencer: RTL

Synthesizable successor to the single-shot simulation run sequence, used to drive one HLS-generated core. It runs the core N times back-to-back and applies a core reset, a one-cycle start pulse and a done wait on each run. It measures the latency of every run in cycles, enforces a timeout watchdog, and pushes one record per run into an internal result FIFO for a host or logger. It sits between the board-level control/debug logic and the core's start_port/done_port pair.

---
 rtl/hls_run_sequencer_if.sv | 18 +
 rtl/hls_run_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/hls_run_sequencer_if.sv
// Result-record stream between hls_run_sequencer and its host/logger.
// master = sequencer (FIFO head), slave = consumer.
interface hls_run_sequencer_if #(
  parameter int CNT_W = 32,
  parameter int RUN_W = 16
);
  localparam int REC_W = CNT_W + RUN_W + 1;

  // Valid/ready: a record moves on every clock edge where res_valid && res_ready.
  // While res_valid=1 and res_ready=0 the master holds res_data unchanged.
  // res_valid never depends on res_ready.
  logic             res_valid;
  logic             res_ready;
  logic [REC_W-1:0] res_data;

  modport master (output res_valid, output res_data, input res_ready);
  modport slave  (input res_valid, input res_data, output res_ready);
endinterface

// File: rtl/hls_run_sequencer.sv
// Runs an HLS core N times (core reset, start pulse, done wait), timing each run
// into a result FIFO. Optional per-sequence latency statistics: RUN_STATS_EN.
module hls_run_sequencer #(
  parameter int CNT_W          = 32,
  parameter int RUN_W          = 16,
  parameter int TIMEOUT_CYCLES = 200000000,
  parameter int RESET_CYCLES   = 2,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   go,
  input  logic [RUN_W-1:0]       run_count,
  output logic                   core_reset,
  output logic                   core_start,
  input  logic                   core_done,
  output logic                   busy,
  output logic                   seq_done,
  output logic                   seq_error,
  output logic [RUN_W-1:0]       run_index,
  hls_run_sequencer_if.master    res,
`ifdef RUN_STATS_EN
  output logic [CNT_W-1:0]       stat_min,
  output logic [CNT_W-1:0]       stat_max,
  output logic [CNT_W+RUN_W-1:0] stat_sum,
`endif
  output logic [2:0]             state_dbg
);

  localparam int REC_W = CNT_W + RUN_W + 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int RC_W  = $clog2(RESET_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO      = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(RESET_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CRST  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_PUSH  = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  state_t           state;
  logic [RC_W-1:0]  rst_cnt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [RUN_W-1:0] last_idx;
  logic             rec_tmo;
  logic [CNT_W-1:0] rec_cyc;

  // Result FIFO storage; pointers carry one extra wrap bit.
  logic [REC_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push_en;
  logic             pop_en;

  assign state_dbg  = state;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // Push is gated only by full: a pop in the same cycle does not make room yet.
  assign push_en    = (state == S_PUSH) && !fifo_full;
  assign pop_en     = !fifo_empty && res.res_ready;

  assign res.res_valid = !fifo_empty;
  assign res.res_data  = fifo_empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Saturating count of the current cycle; the watchdog stops it at TMO.
  assign cnt_inc = (cnt >= TMO) ? cnt : cnt + CNT_W'(1);

  always_ff @(posedge clock) begin
    if (push_en) begin
      mem[wr_ptr[AW-1:0]] <= {rec_tmo, run_index, rec_cyc};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop_en)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      core_reset <= 1'b0;
      core_start <= 1'b0;
      busy       <= 1'b0;
      seq_done   <= 1'b0;
      seq_error  <= 1'b0;
      run_index  <= '0;
      last_idx   <= '0;
      rst_cnt    <= '0;
      cnt        <= '0;
      rec_tmo    <= 1'b0;
      rec_cyc    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          core_reset <= 1'b1;
          if (go) begin
            seq_error <= 1'b0;
            busy      <= 1'b1;
            if (run_count != '0) begin
              state      <= S_CRST;
              core_reset <= 1'b0;
              rst_cnt    <= '0;
              run_index  <= '0;
              last_idx   <= run_count - RUN_W'(1);
            end else begin
              state    <= S_FIN;
              seq_done <= 1'b1;
            end
          end
        end

        S_CRST: begin
          if (rst_cnt == RC_LAST) begin
            state      <= S_START;
            core_reset <= 1'b1;
            core_start <= 1'b1;
          end else begin
            rst_cnt <= rst_cnt + RC_W'(1);
          end
        end

        S_START: begin
          // The start cycle itself counts as cycle 1 of the run.
          core_start <= 1'b0;
          cnt        <= CNT_W'(1);
          state      <= S_WAIT;
        end

        S_WAIT: begin
          if (core_done) begin
            rec_tmo <= 1'b0;
            rec_cyc <= cnt_inc;
            state   <= S_PUSH;
          end else if (cnt_inc >= TMO) begin
            rec_tmo <= 1'b1;
            rec_cyc <= TMO;
            state   <= S_PUSH;
          end else begin
            cnt <= cnt_inc;
          end
        end

        S_PUSH: begin
          if (!fifo_full) begin
            if (rec_tmo) begin
              seq_error <= 1'b1;
              seq_done  <= 1'b1;
              state     <= S_FIN;
            end else if (run_index == last_idx) begin
              seq_done <= 1'b1;
              state    <= S_FIN;
            end else begin
              run_index  <= run_index + RUN_W'(1);
              core_reset <= 1'b0;
              rst_cnt    <= '0;
              state      <= S_CRST;
            end
          end
        end

        S_FIN: begin
          seq_done <= 1'b0;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end

        default: begin
          state      <= S_IDLE;
          core_start <= 1'b0;
          seq_done   <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

`ifdef RUN_STATS_EN
  // Only completed runs contribute; timed-out runs leave the stats untouched.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_min <= '1;
      stat_max <= '0;
      stat_sum <= '0;
    end else if (state == S_IDLE && go) begin
      stat_min <= '1;
      stat_max <= '0;
      stat_sum <= '0;
    end else if (push_en && !rec_tmo) begin
      if (rec_cyc < stat_min) stat_min <= rec_cyc;
      if (rec_cyc > stat_max) stat_max <= rec_cyc;
      stat_sum <= stat_sum + {{RUN_W{1'b0}}, rec_cyc};
    end
  end
`endif

endmodule
